sram_b_raster_reader: RTL and testbench

// - Drains a finished feature map from SRAM group B (b0..b3) and streams it out one activation per handshake.
// - Order: channel-major raster.
// - Inverse of the input-image unshuffle path: storage is 2x2 pixel blocks spread over four banks; output is a plain pixel stream.
// - Sits after the conv/pool pipeline. Triggered by the top-level result-valid pulse; feeds the host/testbench readout port.

---
 rtl/sram_b_raster_reader_if.sv | 48 ++++
 rtl/sram_b_raster_reader.sv | 201 ++++++++++++++++++++
 tb/tb_sram_b_raster_reader.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_b_raster_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_b_raster_reader_if
// Purpose  : Bundles the four SRAM group-B read ports and the activation
//            output stream used by sram_b_raster_reader.
// Ports    : none (signal container only)
//            sram_rdata_b0..b3 - bank read data, valid 1 cycle after address
//            sram_raddr_b0..b3 - bank read addresses
//            out_data/out_valid/out_ready/out_last - activation stream
// Revision : 1.0 - initial release
// ============================================================================
interface sram_b_raster_reader_if #(
    parameter int CH_NUM       = 4,
    parameter int ACT_PER_ADDR = 4,
    parameter int BW_PER_ACT   = 12
);
    localparam int c_WORD_W = CH_NUM * ACT_PER_ADDR * BW_PER_ACT;

    logic [c_WORD_W-1:0]   sram_rdata_b0;
    logic [c_WORD_W-1:0]   sram_rdata_b1;
    logic [c_WORD_W-1:0]   sram_rdata_b2;
    logic [c_WORD_W-1:0]   sram_rdata_b3;
    logic [5:0]            sram_raddr_b0;
    logic [5:0]            sram_raddr_b1;
    logic [5:0]            sram_raddr_b2;
    logic [5:0]            sram_raddr_b3;
    logic [BW_PER_ACT-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    // Reader side
    modport master (
        input  sram_rdata_b0, sram_rdata_b1, sram_rdata_b2, sram_rdata_b3,
        input  out_ready,
        output sram_raddr_b0, sram_raddr_b1, sram_raddr_b2, sram_raddr_b3,
        output out_data, out_valid, out_last
    );

    // SRAM / consumer side
    modport slave (
        output sram_rdata_b0, sram_rdata_b1, sram_rdata_b2, sram_rdata_b3,
        output out_ready,
        input  sram_raddr_b0, sram_raddr_b1, sram_raddr_b2, sram_raddr_b3,
        input  out_data, out_valid, out_last
    );
endinterface
`default_nettype wire

// File: rtl/sram_b_raster_reader.sv
`default_nettype none
// ============================================================================
// Module   : sram_b_raster_reader
// Purpose  : Drains a feature map stored as 2x2 pixel blocks across SRAM
//            banks b0..b3 and streams it out one activation per handshake in
//            channel-major raster order (x innermost, then y, then channel).
// Ports    : clk   - rising-edge clock
//            rst   - asynchronous active-high reset
//            start - 1-cycle pulse, begins a drain (ignored while busy)
//            busy  - high from accepted start until done
//            done  - 1-cycle pulse after the final handshake
//            bus   - SRAM read ports and activation stream (master side)
// Revision : 1.0 - initial release
// ============================================================================
module sram_b_raster_reader #(
    parameter int CH_NUM       = 4,
    parameter int ACT_PER_ADDR = 4,
    parameter int BW_PER_ACT   = 12,
    parameter int IMG_W        = 12,
    parameter int IMG_H        = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    sram_b_raster_reader_if.master        bus
);
    localparam int c_ACTS   = CH_NUM * ACT_PER_ADDR;
    localparam int c_WORD_W = c_ACTS * BW_PER_ACT;
    localparam int c_ADDR_W = 6;
    localparam int c_CW     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int c_XW     = $clog2(IMG_W);
    localparam int c_YW     = $clog2(IMG_H);

    localparam logic [c_CW-1:0] c_C_LAST = c_CW'(CH_NUM - 1);
    localparam logic [c_YW-1:0] c_Y_LAST = c_YW'(IMG_H - 1);
    localparam logic [c_XW-1:0] c_X_LAST = c_XW'(IMG_W - 2);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_RD   = 3'd1;
    localparam logic [2:0] c_CAP  = 3'd2;
    localparam logic [2:0] c_TX0  = 3'd3;
    localparam logic [2:0] c_TX1  = 3'd4;
    localparam logic [2:0] c_FIN  = 3'd5;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [c_CW-1:0]       r_c, w_c_nxt;
    logic [c_YW-1:0]       r_y, w_y_nxt;
    logic [c_XW-1:0]       r_x, w_x_nxt;
    logic [1:0]            r_bank;
    logic [c_WORD_W-1:0]   r_word;
    logic [c_ADDR_W-1:0]   r_raddr_b0, r_raddr_b1, r_raddr_b2, r_raddr_b3;
    logic [BW_PER_ACT-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_hs;
    logic                  w_is_last;
    logic [1:0]            w_bank;
    logic [c_ADDR_W-1:0]   w_addr;
    logic [c_WORD_W-1:0]   w_rdata_sel;
    logic [c_WORD_W-1:0]   w_word_src;
    logic [BW_PER_ACT-1:0] w_acts [c_ACTS];
    logic                  w_odd;
    logic [c_CW+1:0]       w_k;

    assign w_hs      = r_out_valid && bus.out_ready;
    assign w_is_last = (r_c == c_C_LAST) && (r_y == c_Y_LAST) && (r_x == c_X_LAST);

    // Next-state and counter advance
    always_comb begin
        w_state_nxt = r_state;
        w_c_nxt     = r_c;
        w_y_nxt     = r_y;
        w_x_nxt     = r_x;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = c_RD;
                    w_c_nxt     = '0;
                    w_y_nxt     = '0;
                    w_x_nxt     = '0;
                end
            end
            c_RD:  w_state_nxt = c_CAP;
            c_CAP: w_state_nxt = c_TX0;
            c_TX0: begin
                if (w_hs) w_state_nxt = c_TX1;
            end
            c_TX1: begin
                if (w_hs) begin
                    if (w_is_last) begin
                        w_state_nxt = c_FIN;
                    end else begin
                        w_state_nxt = c_RD;
                        if (r_x == c_X_LAST) begin
                            w_x_nxt = '0;
                            if (r_y == c_Y_LAST) begin
                                w_y_nxt = '0;
                                w_c_nxt = r_c + c_CW'(1);
                            end else begin
                                w_y_nxt = r_y + c_YW'(1);
                            end
                        end else begin
                            w_x_nxt = r_x + c_XW'(2);
                        end
                    end
                end
            end
            c_FIN:   w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Address of the word holding the pixel pair about to be read. Registered
    // outputs are loaded from the next-cycle counters so raddr is valid in RD.
    assign w_bank = {w_y_nxt[1], w_x_nxt[1]};
    assign w_addr = c_ADDR_W'((32'(w_y_nxt) >> 2) * 32'(IMG_W / 4) + (32'(w_x_nxt) >> 2));

    always_comb begin
        w_rdata_sel = bus.sram_rdata_b0;
        case (r_bank)
            2'd0: w_rdata_sel = bus.sram_rdata_b0;
            2'd1: w_rdata_sel = bus.sram_rdata_b1;
            2'd2: w_rdata_sel = bus.sram_rdata_b2;
            2'd3: w_rdata_sel = bus.sram_rdata_b3;
            default: w_rdata_sel = bus.sram_rdata_b0;
        endcase
    end

    // In CAP the word register is being loaded this edge, so the first pixel
    // of the pair is sliced straight from the bank data.
    assign w_word_src = (r_state == c_CAP) ? w_rdata_sel : r_word;

    // k = 0 occupies the most significant slice
    for (genvar gi = 0; gi < c_ACTS; gi++) begin : g_unpack
        assign w_acts[gi] = w_word_src[(c_ACTS-1-gi)*BW_PER_ACT +: BW_PER_ACT];
    end

    // Leaving CAP loads the even pixel, leaving TX0 loads the odd one
    assign w_odd = (r_state == c_TX0);
    assign w_k   = {r_c, r_y[0], w_odd};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_c         <= '0;
            r_y         <= '0;
            r_x         <= '0;
            r_bank      <= '0;
            r_word      <= '0;
            r_raddr_b0  <= '0;
            r_raddr_b1  <= '0;
            r_raddr_b2  <= '0;
            r_raddr_b3  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_c         <= w_c_nxt;
            r_y         <= w_y_nxt;
            r_x         <= w_x_nxt;
            r_busy      <= (w_state_nxt == c_RD) || (w_state_nxt == c_CAP) ||
                           (w_state_nxt == c_TX0) || (w_state_nxt == c_TX1);
            r_done      <= (w_state_nxt == c_FIN);
            r_out_valid <= (w_state_nxt == c_TX0) || (w_state_nxt == c_TX1);
            r_out_last  <= (w_state_nxt == c_TX1) && w_is_last;
            r_raddr_b0  <= (w_state_nxt == c_RD && w_bank == 2'd0) ? w_addr : '0;
            r_raddr_b1  <= (w_state_nxt == c_RD && w_bank == 2'd1) ? w_addr : '0;
            r_raddr_b2  <= (w_state_nxt == c_RD && w_bank == 2'd2) ? w_addr : '0;
            r_raddr_b3  <= (w_state_nxt == c_RD && w_bank == 2'd3) ? w_addr : '0;
            if (w_state_nxt == c_RD) begin
                r_bank <= w_bank;
            end
            if (r_state == c_CAP) begin
                r_word <= w_rdata_sel;
            end
            if ((r_state == c_CAP) || (r_state == c_TX0 && w_hs)) begin
                r_out_data <= w_acts[w_k];
            end
        end
    end

    assign busy              = r_busy;
    assign done              = r_done;
    assign bus.out_data      = r_out_data;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_last      = r_out_last;
    assign bus.sram_raddr_b0 = r_raddr_b0;
    assign bus.sram_raddr_b1 = r_raddr_b1;
    assign bus.sram_raddr_b2 = r_raddr_b2;
    assign bus.sram_raddr_b3 = r_raddr_b3;
endmodule
`default_nettype wire

// File: tb/tb_sram_b_raster_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_b_raster_reader
// Purpose  : Self-checking bench for sram_b_raster_reader. A banked SRAM
//            model is loaded from a plain per-pixel table; the expected beat
//            stream and read addresses are derived from that table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_b_raster_reader;
    localparam int CH     = 4;
    localparam int BW     = 12;
    localparam int W      = 12;
    localparam int H      = 12;
    localparam int NACT   = CH * 4;
    localparam int WORD_W = NACT * BW;
    localparam int TOTAL  = CH * W * H;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic done;

    sram_b_raster_reader_if #(.CH_NUM(CH), .ACT_PER_ADDR(4), .BW_PER_ACT(BW)) bus ();

    sram_b_raster_reader #(
        .CH_NUM(CH), .ACT_PER_ADDR(4), .BW_PER_ACT(BW), .IMG_W(W), .IMG_H(H)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    logic [BW-1:0]     pix [CH][H][W];
    logic [WORD_W-1:0] mem [4][64];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int s_cyc = 0;
    int beat = 0;
    int done_cnt = 0;
    int last_hs_cyc = 0;
    bit addr_chk = 0;
    bit ready_rnd = 0;
    logic prev_stall = 0;
    logic prev_last = 0;
    logic [BW-1:0] prev_data = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read SRAM banks
    always @(posedge clk) begin
        bus.sram_rdata_b0 <= mem[0][bus.sram_raddr_b0];
        bus.sram_rdata_b1 <= mem[1][bus.sram_raddr_b1];
        bus.sram_rdata_b2 <= mem[2][bus.sram_raddr_b2];
        bus.sram_rdata_b3 <= mem[3][bus.sram_raddr_b3];
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = ready_rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] exp_val(input int i);
        return pix[i / (W * H)][(i / W) % H][i % W];
    endfunction

    // Expected {b3,b2,b1,b0} read addresses for pixel pair p
    function automatic logic [23:0] exp_raddr(input int p);
        int q, x, y, br, bc, bank, addr;
        logic [23:0] v;
        q    = 2 * p;
        x    = q % W;
        y    = (q / W) % H;
        br   = y / 2;
        bc   = x / 2;
        bank = (br % 2) * 2 + (bc % 2);
        addr = (br / 2) * (W / 4) + (bc / 2);
        v    = 24'(addr) << (6 * bank);
        return v;
    endfunction

    task automatic fill_pattern(input bit rnd);
        logic [1:0] cc;
        logic [3:0] yy, xx;
        int br, bc, bank, addr, k;
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 64; a++)
                for (int s = 0; s < NACT; s++)
                    mem[b][a][s*BW +: BW] = BW'($urandom);
        for (int c = 0; c < CH; c++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) begin
                    cc = 2'(c);
                    yy = 4'(y);
                    xx = 4'(x);
                    pix[c][y][x] = rnd ? BW'($urandom) : {cc, yy, xx, 2'b00};
                    br   = y / 2;
                    bc   = x / 2;
                    bank = (br % 2) * 2 + (bc % 2);
                    addr = (br / 2) * (W / 4) + (bc / 2);
                    k    = c * 4 + (y % 2) * 2 + (x % 2);
                    mem[bank][addr][(NACT-1-k)*BW +: BW] = pix[c][y][x];
                end
    endtask

    // Stream monitor: order, hold-under-backpressure, done timing, RD addresses
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_value("hold_valid", 32'(bus.out_valid), 32'd1);
                check_value("hold_data", 32'(bus.out_data), 32'(prev_data));
                check_value("hold_last", 32'(bus.out_last), 32'(prev_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (beat < TOTAL) begin
                    check_value("beat_data", 32'(bus.out_data), 32'(exp_val(beat)));
                    check_value("beat_last", 32'(bus.out_last), 32'(beat == TOTAL - 1));
                end else begin
                    check_value("beat_overrun", 32'(beat), 32'(TOTAL - 1));
                end
                last_hs_cyc = cyc;
                beat++;
            end
            if (done) begin
                done_cnt++;
                check_value("done_gap", 32'(cyc - last_hs_cyc), 32'd1);
                check_value("done_busy", 32'(busy), 32'd0);
            end
            if (addr_chk && ((cyc - s_cyc) % 4) == 0 && ((cyc - s_cyc) / 4) < TOTAL / 2)
                check_value("raddr", 32'({bus.sram_raddr_b3, bus.sram_raddr_b2,
                                          bus.sram_raddr_b1, bus.sram_raddr_b0}),
                            32'(exp_raddr((cyc - s_cyc) / 4)));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end
    end

    task automatic check_all_zero(input string tag);
        check_value({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check_value({tag, "_busy"}, 32'(busy), 32'd0);
        check_value({tag, "_done"}, 32'(done), 32'd0);
        check_value({tag, "_last"}, 32'(bus.out_last), 32'd0);
        check_value({tag, "_data"}, 32'(bus.out_data), 32'd0);
        check_value({tag, "_raddr"}, 32'({bus.sram_raddr_b3, bus.sram_raddr_b2,
                                          bus.sram_raddr_b1, bus.sram_raddr_b0}), 32'd0);
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        s_cyc = cyc;
    endtask

    task automatic run_drain(input bit rnd, input bit lat_chk, input bit inject, input int abort_beat);
        bit injected;
        int i;
        injected  = 1'b0;
        ready_rnd = rnd;
        beat      = 0;
        done_cnt  = 0;
        start_pulse();
        if (lat_chk) begin
            addr_chk = 1'b1;
            @(negedge clk);
            check_value("lat_busy", 32'(busy), 32'd1);
            check_value("lat_valid1", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
            check_value("lat_valid2", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
            check_value("lat_valid3", 32'(bus.out_valid), 32'd1);
        end
        for (i = 0; i < 20000 && done_cnt == 0; i++) begin
            @(negedge clk);
            if (inject && !injected && beat >= 100) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                injected = 1'b1;
            end
            if (abort_beat > 0 && beat >= abort_beat) begin
                @(posedge clk);
                #3;
                rst = 1'b1;
                #1;
                check_all_zero("abort");
                repeat (3) @(negedge clk);
                check_value("abort_no_done", 32'(done_cnt), 32'd0);
                rst = 1'b0;
                addr_chk = 1'b0;
                return;
            end
        end
        check_value("drain_timeout", 32'(i < 20000), 32'd1);
        repeat (4) @(negedge clk);
        check_value("beat_total", 32'(beat), 32'(TOTAL));
        check_value("done_count", 32'(done_cnt), 32'd1);
        check_value("end_busy", 32'(busy), 32'd0);
        addr_chk = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        fill_pattern(1'b0);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Coordinate pattern, full-rate, latency and bank/addr walk
        run_drain(1'b0, 1'b1, 1'b0, 0);
        // Random data under random backpressure
        fill_pattern(1'b1);
        run_drain(1'b1, 1'b0, 1'b0, 0);
        // Start pulse while busy must be ignored
        run_drain(1'b1, 1'b0, 1'b1, 0);
        // Abort at beat 200, then restart from pixel (0,0,0)
        fill_pattern(1'b1);
        run_drain(1'b1, 1'b0, 1'b0, 200);
        repeat (2) @(negedge clk);
        run_drain(1'b1, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
